// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and types for the VGA raster path.
//   - localparams for the 640x480@60 timing set (defaults of vga_timing_gen)
//   - rgb12_t : packed {r,g,b} 4 bits each
//   - htotal()/vtotal() : total pixels per line / lines per frame
package vga_pkg;

  localparam int VGA640_HACTIVE = 640;
  localparam int VGA640_HFP     = 16;
  localparam int VGA640_HSYN    = 96;
  localparam int VGA640_HBP     = 48;
  localparam int VGA640_VACTIVE = 480;
  localparam int VGA640_VFP     = 10;
  localparam int VGA640_VSYN    = 2;
  localparam int VGA640_VBP     = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  function automatic int htotal(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  function automatic int vtotal(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register with enable and synchronous reset.
// Every stage loads RST_VAL on reset, so the output is defined from the first
// cycle after reset rather than after the line has filled.
//   vgaclk : clock (rising edge)
//   reset  : synchronous, active-high
//   en     : shift enable; 0 holds every stage
//   d      : W-bit input
//   q      : W-bit output, d delayed by DEPTH enabled cycles
module vga_sync_delay #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         vgaclk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stage;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      stage <= {DEPTH{RST_VAL}};
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// x/y counters run on the pixel clock; line_start/frame_start/x/y are zero
// latency. hsync/vsync/blank_b are delayed PIPE_DLY cycles so they line up with
// rgb_in from a pipelined pixel generator; r/g/b are blanked outside the
// active area.
// Optional feature macro: VGA_TEST_PATTERN_EN (8-bar colour test pattern,
// selected by test_en). Without it test_en is ignored.
// Ports:
//   vgaclk, reset (sync, active-high), en (count enable)
//   x, y, line_start, frame_start, frame_cnt : raster position / strobes
//   rgb_in, test_en : pixel input and pattern select
//   hsync, vsync, sync_b, blank_b, r, g, b   : delayed display outputs
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HACTIVE  = VGA640_HACTIVE,
  parameter int HFP      = VGA640_HFP,
  parameter int HSYN     = VGA640_HSYN,
  parameter int HBP      = VGA640_HBP,
  parameter int VACTIVE  = VGA640_VACTIVE,
  parameter int VFP      = VGA640_VFP,
  parameter int VSYN     = VGA640_VSYN,
  parameter int VBP      = VGA640_VBP,
  parameter bit HPOL     = 1'b0,
  parameter bit VPOL     = 1'b0,
  parameter int PIPE_DLY = 1,
  parameter int CW       = 10,
  parameter int FCW      = 8
) (
  input  logic           vgaclk,
  input  logic           reset,
  input  logic           en,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt,
  input  logic [11:0]    rgb_in,
  input  logic           test_en,
  output logic           hsync,
  output logic           vsync,
  output logic           sync_b,
  output logic           blank_b,
  output logic [3:0]     r,
  output logic [3:0]     g,
  output logic [3:0]     b
);

  localparam int HTOTAL = htotal(HACTIVE, HFP, HSYN, HBP);
  localparam int VTOTAL = vtotal(VACTIVE, VFP, VSYN, VBP);

  // All bounds are inclusive "last" values so no constant needs CW+1 bits.
  localparam logic [CW-1:0] H_LAST    = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LST = CW'(HACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LST = CW'(VACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST  = CW'(HACTIVE + HFP);
  localparam logic [CW-1:0] HS_LAST   = CW'(HACTIVE + HFP + HSYN - 1);
  localparam logic [CW-1:0] VS_FIRST  = CW'(VACTIVE + VFP);
  localparam logic [CW-1:0] VS_LAST   = CW'(VACTIVE + VFP + VSYN - 1);

  // Raster counters
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      if (x == H_LAST) begin
        x <= '0;
        if (y == V_LAST) begin
          y         <= '0;
          frame_cnt <= frame_cnt + FCW'(1);
        end else begin
          y <= y + CW'(1);
        end
      end else begin
        x <= x + CW'(1);
      end
    end
  end

  assign line_start  = (x == '0);
  assign frame_start = line_start && (y == '0);

  // Raw sync/blank terms, kept active-high until the output stage
  logic hs_raw, vs_raw, act;
  logic hs_d, vs_d, act_d;

  assign hs_raw = (x >= HS_FIRST) && (x <= HS_LAST);
  assign vs_raw = (y >= VS_FIRST) && (y <= VS_LAST);
  assign act    = (x <= H_ACT_LST) && (y <= V_ACT_LST);

  // Reset value 0 = sync inactive and blanked once polarity is applied
  vga_sync_delay #(.W(3), .DEPTH(PIPE_DLY), .RST_VAL(3'b000)) u_sync_dly (
    .vgaclk (vgaclk),
    .reset  (reset),
    .en     (en),
    .d      ({hs_raw, vs_raw, act}),
    .q      ({hs_d, vs_d, act_d})
  );

  assign hsync   = hs_d ^ ~HPOL;
  assign vsync   = vs_d ^ ~VPOL;
  assign sync_b  = hsync & vsync;
  assign blank_b = act_d;

  rgb12_t pix;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = HACTIVE / 8;

  logic [2:0] bar;
  rgb12_t     pat, pat_d;
  logic       sel_d;

  // Bar index wraps past the active area; those pixels are blanked anyway.
  assign bar = 3'(x / CW'(BAR_W));
  assign pat = '{r: {4{bar[2]}}, g: {4{bar[1]}}, b: {4{bar[0]}}};

  // test_en travels with its pixel so a mid-line switch stays aligned
  vga_sync_delay #(.W(13), .DEPTH(PIPE_DLY), .RST_VAL(13'h0)) u_pat_dly (
    .vgaclk (vgaclk),
    .reset  (reset),
    .en     (en),
    .d      ({test_en, pat}),
    .q      ({sel_d, pat_d})
  );

  assign pix = sel_d ? pat_d : rgb12_t'(rgb_in);
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
  assign pix = rgb12_t'(rgb_in);
`endif

  assign r = blank_b ? pix.r : 4'h0;
  assign g = blank_b ? pix.g : 4'h0;
  assign b = blank_b ? pix.b : 4'h0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized scoreboard bench for vga_timing_gen.
// Uses a small raster (24x13) with PIPE_DLY=3, HPOL=1, FCW=2 so many frames and
// the frame counter wrap fit in a short run. The reference model tracks only
// the number of enabled cycles since reset and derives every output from it
// with division/modulo.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int PD = 3, CW = 10, FCW = 2;

  logic           vgaclk = 1'b0;
  logic           reset, en, test_en;
  logic [11:0]    rgb_in;
  logic [CW-1:0]  x, y;
  logic           line_start, frame_start;
  logic [FCW-1:0] frame_cnt;
  logic           hsync, vsync, sync_b, blank_b;
  logic [3:0]     r, g, b;

  always #5 vgaclk = ~vgaclk;

  vga_timing_gen #(
    .HACTIVE(HA), .HFP(HF), .HSYN(HS), .HBP(HB),
    .VACTIVE(VA), .VFP(VF), .VSYN(VS), .VBP(VB),
    .HPOL(HP), .VPOL(VP), .PIPE_DLY(PD), .CW(CW), .FCW(FCW)
  ) dut (
    .vgaclk(vgaclk), .reset(reset), .en(en),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .rgb_in(rgb_in), .test_en(test_en),
    .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
    .r(r), .g(g), .b(b)
  );

  typedef struct {
    int          ex, ey, efc;
    bit          els, efs, ehs, evs, esb, ebb;
    logic [11:0] ergb;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   t = 0;                 // enabled cycles since last reset
  bit   te_at [0:8191];        // test_en seen at each enabled position

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int tt, input logic [11:0] rgb);
    exp_t e;
    int   u, xu, yu, bar;
    bit   hs, vs, act;
    logic [11:0] pix;
    e.ex  = tt % HT;
    e.ey  = (tt / HT) % VT;
    e.efc = (tt / (HT * VT)) % (1 << FCW);
    e.els = (e.ex == 0);
    e.efs = (e.ex == 0) && (e.ey == 0);
    hs = 0; vs = 0; act = 0; pix = rgb;
    if (tt >= PD) begin
      u   = tt - PD;
      xu  = u % HT;
      yu  = (u / HT) % VT;
      hs  = (xu >= HA + HF) && (xu < HA + HF + HS);
      vs  = (yu >= VA + VF) && (yu < VA + VF + VS);
      act = (xu < HA) && (yu < VA);
`ifdef VGA_TEST_PATTERN_EN
      if (te_at[u]) begin
        bar = (xu / (HA / 8)) % 8;
        pix = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      end
`endif
    end
    e.ehs  = HP ? hs : !hs;
    e.evs  = VP ? vs : !vs;
    e.esb  = e.ehs && e.evs;
    e.ebb  = act;
    e.ergb = act ? pix : 12'h000;
    return e;
  endfunction

  // Monitor: outputs are valid every cycle; compare away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge vgaclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("x",           int'(x),           e.ex);
        chk("y",           int'(y),           e.ey);
        chk("line_start",  int'(line_start),  int'(e.els));
        chk("frame_start", int'(frame_start), int'(e.efs));
        chk("frame_cnt",   int'(frame_cnt),   e.efc);
        chk("hsync",       int'(hsync),       int'(e.ehs));
        chk("vsync",       int'(vsync),       int'(e.evs));
        chk("sync_b",      int'(sync_b),      int'(e.esb));
        chk("blank_b",     int'(blank_b),     int'(e.ebb));
        chk("rgb",         int'({r, g, b}),   int'(e.ergb));
      end
    end
  end

  // Driver + model update
  initial begin
    reset = 1'b1; en = 1'b0; test_en = 1'b0; rgb_in = 12'h0;
    repeat (2) @(posedge vgaclk);
    for (int c = 0; c < 3200; c++) begin
      @(posedge vgaclk); #1;
      // account for the edge that just happened, using the inputs it saw
      if (reset) t = 0;
      else if (en) begin
        te_at[t] = test_en;
        t++;
      end
      // new inputs: long reset-free stretch first so the frame counter wraps
      reset   = (c < 2000) ? 1'b0 : ($urandom_range(0, 149) == 0);
      en      = ($urandom_range(0, 99) < 85);
      test_en = 1'($urandom_range(0, 1));
      rgb_in  = 12'($urandom);
      q.push_back(model(t, rgb_in));
    end
    repeat (3) @(posedge vgaclk);
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
